// File: rtl/core_pkg.sv
// Shared definitions for the RV32I front end: word width, bubble encoding and
// the fetch FSM state type.
package core_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/core_ifid_reg.sv
// IF/ID pipeline register: flush beats write, a write with nothing delivered
// loads a bubble, otherwise the register holds.
module core_ifid_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            write,
  input  logic            flush,
  input  logic            load_valid,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_instr,
  output logic            ifid_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (flush) begin
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (write) begin
      if (load_valid) begin
        ifid_pc    <= load_pc;
        ifid_instr <= load_instr;
        ifid_valid <= 1'b1;
      end else begin
        // PC is left as-is on a bubble; only the valid/instr pair matters
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/core_ifetch.sv
// Instruction-fetch stage: PC register, single-outstanding read on the
// instruction-memory channel, redirect handling and the IF/ID register.
module core_ifetch
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            HCU_PC_WRITE,
  input  logic            HCU_IFID_WRITE,
  input  logic            HCU_IFID_FLUSH,
  input  logic            REDIRECT_VALID,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            IMEM_ARVALID,
  output logic [XLEN-1:0] IMEM_ARADDR,
  input  logic            IMEM_ARREADY,
  input  logic            IMEM_RVALID,
  input  logic [XLEN-1:0] IMEM_RDATA,
  output logic            IMEM_RREADY,
  output logic            HCU_IMEM_BUSY,
  output logic            HCU_IMEM_DONE,
  output logic [XLEN-1:0] IFID_PC,
  output logic [XLEN-1:0] IFID_INSTR,
  output logic            IFID_VALID
);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] buf_instr_reg, buf_instr_next;
  logic [XLEN-1:0] pend_pc_reg, pend_pc_next;
  logic            discard_reg, discard_next;

  logic            in_req, in_wait, in_hold;
  logic            advance;
  logic            load_valid;
  logic [XLEN-1:0] load_instr;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pc_plus4;

  assign in_req          = (state_reg == ST_REQ);
  assign in_wait         = (state_reg == ST_WAIT);
  assign in_hold         = (state_reg == ST_HOLD);
  assign advance         = HCU_PC_WRITE & HCU_IFID_WRITE;
  assign redirect_target = REDIRECT_PC & ~32'd3;
  assign pc_plus4        = pc_reg + 32'd4;

  assign IMEM_ARVALID  = in_req;
  assign IMEM_ARADDR   = pc_reg;
  assign IMEM_RREADY   = in_wait;
  // Status depends only on state and memory/redirect inputs, never on HCU outputs
  assign HCU_IMEM_BUSY = in_req | (in_wait & ~IMEM_RVALID) | discard_reg;
  assign HCU_IMEM_DONE = in_wait & IMEM_RVALID & ~discard_reg & ~REDIRECT_VALID;

  assign load_valid = (HCU_IMEM_DONE & advance) | (in_hold & ~REDIRECT_VALID & advance);
  assign load_instr = in_hold ? buf_instr_reg : IMEM_RDATA;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    buf_instr_next = buf_instr_reg;
    pend_pc_next   = pend_pc_reg;
    discard_next   = discard_reg;
    case (state_reg)
      ST_IDLE: begin
        state_next = ST_REQ;
        if (REDIRECT_VALID) pc_next = redirect_target;
      end
      ST_REQ: begin
        // Address must stay stable mid-handshake, so a redirect is deferred
        if (REDIRECT_VALID) begin
          discard_next = 1'b1;
          pend_pc_next = redirect_target;
        end
        if (IMEM_ARREADY) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (IMEM_RVALID) begin
          if (REDIRECT_VALID) begin
            pc_next      = redirect_target;
            discard_next = 1'b0;
            state_next   = ST_REQ;
          end else if (discard_reg) begin
            pc_next      = pend_pc_reg;
            discard_next = 1'b0;
            state_next   = ST_REQ;
          end else if (advance) begin
            pc_next    = pc_plus4;
            state_next = ST_REQ;
          end else begin
            buf_instr_next = IMEM_RDATA;
            state_next     = ST_HOLD;
          end
        end else if (REDIRECT_VALID) begin
          discard_next = 1'b1;
          pend_pc_next = redirect_target;
        end
      end
      ST_HOLD: begin
        if (REDIRECT_VALID) begin
          pc_next    = redirect_target;
          state_next = ST_REQ;
        end else if (advance) begin
          pc_next    = pc_plus4;
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= RESET_PC;
      buf_instr_reg <= NOP_INSTR;
      pend_pc_reg   <= '0;
      discard_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      buf_instr_reg <= buf_instr_next;
      pend_pc_reg   <= pend_pc_next;
      discard_reg   <= discard_next;
    end
  end

  core_ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk        (CLK),
    .rst        (RST),
    .write      (HCU_IFID_WRITE),
    .flush      (HCU_IFID_FLUSH),
    .load_valid (load_valid),
    .load_pc    (pc_reg),
    .load_instr (load_instr),
    .ifid_pc    (IFID_PC),
    .ifid_instr (IFID_INSTR),
    .ifid_valid (IFID_VALID)
  );

endmodule

// File: tb/tb_core_ifetch.sv
// Bench for core_ifetch: directed scenarios, then random traffic against a
// program-order fetch model with a latency-randomised memory.
module tb_core_ifetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST;
  logic        pw, iw, fl, rv;
  logic [31:0] rpc;
  logic        arready, rvalid;
  logic [31:0] rdata;

  logic        arvalid, rready, busy, done, ifid_valid;
  logic [31:0] araddr, ifid_pc, ifid_instr;

  logic        d2_arvalid, d2_rready, d2_busy, d2_done, d2_ifid_valid;
  logic [31:0] d2_araddr, d2_ifid_pc, d2_ifid_instr;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  core_ifetch u_dut (
    .CLK(CLK), .RST(RST),
    .HCU_PC_WRITE(pw), .HCU_IFID_WRITE(iw), .HCU_IFID_FLUSH(fl),
    .REDIRECT_VALID(rv), .REDIRECT_PC(rpc),
    .IMEM_ARVALID(arvalid), .IMEM_ARADDR(araddr), .IMEM_ARREADY(arready),
    .IMEM_RVALID(rvalid), .IMEM_RDATA(rdata), .IMEM_RREADY(rready),
    .HCU_IMEM_BUSY(busy), .HCU_IMEM_DONE(done),
    .IFID_PC(ifid_pc), .IFID_INSTR(ifid_instr), .IFID_VALID(ifid_valid)
  );

  core_ifetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .CLK(CLK), .RST(RST),
    .HCU_PC_WRITE(pw), .HCU_IFID_WRITE(iw), .HCU_IFID_FLUSH(fl),
    .REDIRECT_VALID(rv), .REDIRECT_PC(rpc),
    .IMEM_ARVALID(d2_arvalid), .IMEM_ARADDR(d2_araddr), .IMEM_ARREADY(arready),
    .IMEM_RVALID(rvalid), .IMEM_RDATA(rdata), .IMEM_RREADY(d2_rready),
    .HCU_IMEM_BUSY(d2_busy), .HCU_IMEM_DONE(d2_done),
    .IFID_PC(d2_ifid_pc), .IFID_INSTR(d2_ifid_instr), .IFID_VALID(d2_ifid_valid)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_0000;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic zero_inputs();
    pw = 0; iw = 0; fl = 0; rv = 0; rpc = '0;
    arready = 0; rvalid = 0; rdata = '0;
  endtask

  // Reference model state (random phase)
  logic [31:0] exp_pc, exp_p, exp_i, mem_addr;
  logic        exp_v, have_word, mem_busy, stale, hs_r, deliver, exp_busy, exp_done;
  int          mem_delay, deliveries;

  task automatic model_reset();
    exp_pc = 32'h0; have_word = 0; exp_v = 0; exp_i = NOP; exp_p = 32'h0;
    mem_busy = 0; mem_addr = '0; mem_delay = 0; stale = 0;
  endtask

  initial begin
    zero_inputs();
    RST = 1;
    deliveries = 0;
    step(); step();
    check_val("rst_valid", ifid_valid, 0);
    check_val("rst_instr", ifid_instr, NOP);
    check_val("rst_pc", ifid_pc, 0);
    check_val("rst_arvalid", arvalid, 0);
    check_val("rst_rready", rready, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);

    // Zero-wait memory, straight-line fetch
    RST = 0;
    pw = 1; iw = 1; arready = 1; rvalid = 1; rdata = 32'h0000_0093;
    step();                                          // E1: IDLE -> REQ
    check_val("ar0_valid", arvalid, 1);
    check_val("ar0_addr", araddr, 32'h0);
    check_val("ar0_busy", busy, 1);
    check_val("wrap_ar0", d2_araddr, 32'hFFFF_FFFC);
    step();                                          // E2: accepted
    check_val("wait_rready", rready, 1);
    check_val("wait_done", done, 1);
    check_val("wait_busy", busy, 0);
    step();                                          // E3: IF/ID loaded
    check_val("seq0_valid", ifid_valid, 1);
    check_val("seq0_pc", ifid_pc, 32'h0);
    check_val("seq0_instr", ifid_instr, 32'h0000_0093);
    check_val("ar1_addr", araddr, 32'h4);
    check_val("wrap_ar1", d2_araddr, 32'h0);
    step(); step();                                  // E5
    check_val("ar2_addr", araddr, 32'h8);
    check_val("seq1_pc", ifid_pc, 32'h4);
    $display("seq: addresses 0,4,8 issued");

    // Stall IF/ID for three cycles while data arrives
    step();                                          // E6: accept 8
    iw = 0; rdata = 32'h0050_0113;
    step();                                          // E7: -> HOLD
    rvalid = 0;
    #1;
    check_val("hold_arvalid0", arvalid, 0);
    check_val("hold_ifid_pc", ifid_pc, 32'h4);
    step();
    check_val("hold_arvalid1", arvalid, 0);
    step();
    check_val("hold_arvalid2", arvalid, 0);
    check_val("hold_busy", busy, 0);
    iw = 1;
    step();                                          // E10: buffered word loaded
    check_val("hold_out_pc", ifid_pc, 32'h8);
    check_val("hold_out_instr", ifid_instr, 32'h0050_0113);
    check_val("hold_out_valid", ifid_valid, 1);
    check_val("hold_next_ar", araddr, 32'hC);
    $display("hold: buffered word delivered at pc 8");

    // Redirect in WAIT, response two cycles later must be discarded
    step();                                          // E11: accept 12
    rv = 1; rpc = 32'h0000_0100;
    step();                                          // E12
    rv = 0;
    step();                                          // E13
    rvalid = 1; rdata = 32'hDEAD_0001;
    #1;
    check_val("disc_done", done, 0);
    check_val("disc_busy", busy, 1);
    step();                                          // E14
    rvalid = 0;
    #1;
    check_val("redir_ar", araddr, 32'h100);
    check_val("redir_arvalid", arvalid, 1);
    check_val("redir_bubble", ifid_valid, 0);
    $display("redirect-in-wait: next fetch 0x100");

    // Deliver 0x100, then redirect coincident with RVALID
    step();                                          // E15: accept 0x100
    rvalid = 1; rdata = 32'h0010_0093;
    step();                                          // E16: delivered
    rvalid = 0; iw = 0;
    #1;
    check_val("x1_pc", ifid_pc, 32'h100);
    step();                                          // E17: accept 0x104
    rvalid = 1; rdata = 32'hBAD0_BAD0; rv = 1; rpc = 32'h0000_0203;
    #1;
    check_val("same_done", done, 0);
    step();                                          // E18
    rv = 0; rvalid = 0;
    #1;
    check_val("same_ar", araddr, 32'h200);
    check_val("same_ifid_pc", ifid_pc, 32'h100);
    check_val("same_ifid_instr", ifid_instr, 32'h0010_0093);
    check_val("same_ifid_valid", ifid_valid, 1);
    $display("redirect-with-rvalid: next fetch 0x200");

    // Flush beats write
    fl = 1; iw = 1;
    step();
    fl = 0;
    check_val("flush_valid", ifid_valid, 0);
    check_val("flush_instr", ifid_instr, NOP);
    $display("flush: bubble inserted");

    // Random phase
    zero_inputs();
    RST = 1;
    @(negedge CLK); @(negedge CLK);
    RST = 0;
    model_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge CLK);
      if (cyc == 1000) begin
        zero_inputs();
        #2 RST = 1;
        #1;
        check_val("async_rst_valid", ifid_valid, 0);
        check_val("async_rst_arvalid", arvalid, 0);
        @(negedge CLK); @(negedge CLK);
        RST = 0;
        model_reset();
        @(negedge CLK);
      end
      check_val("r_valid", ifid_valid, exp_v);
      if (exp_v) begin
        check_val("r_pc", ifid_pc, exp_p);
        check_val("r_instr", ifid_instr, exp_i);
      end

      pw = ($urandom % 4) != 0;
      iw = ($urandom % 4) != 0;
      fl = !iw && (($urandom % 8) == 0);
      rv = ($urandom % 12) == 0;
      rpc = $urandom_range(0, 4095);
      while ((mem_busy && ((rpc & ~32'd3) == mem_addr)) ||
             (arvalid && ((rpc & ~32'd3) == araddr)))
        rpc = rpc + 32'd8;
      arready = ($urandom % 4) != 0;
      rvalid  = mem_busy && (mem_delay == 0);
      rdata   = rvalid ? memf(mem_addr) : $urandom;
      #1;

      hs_r     = rvalid && mem_busy;
      exp_done = hs_r && (mem_addr == exp_pc) && !rv;
      exp_busy = arvalid || (mem_busy && !(rvalid && (mem_addr == exp_pc)));
      check_val("r_rready", rready, mem_busy);
      check_val("r_done", done, exp_done);
      check_val("r_busy", busy, exp_busy);

      if (rv && arvalid) stale = 1;
      if (arvalid && arready) begin
        if (!stale) check_val("r_araddr", araddr, exp_pc);
        check_val("r_one_outstanding", mem_busy, 0);
        stale = 0;
      end

      deliver = 0;
      if (rv) begin
        have_word = 0;
        exp_pc = rpc & ~32'd3;
      end else begin
        if (hs_r && (mem_addr == exp_pc)) have_word = 1;
        if (have_word && pw && iw) deliver = 1;
      end

      if (fl) begin
        exp_v = 0; exp_i = NOP;
      end else if (iw) begin
        if (deliver) begin
          exp_v = 1; exp_i = memf(exp_pc); exp_p = exp_pc;
          $display("fetch pc=%h instr=%h", exp_pc, exp_i);
          have_word = 0;
          exp_pc = exp_pc + 32'd4;
          deliveries++;
        end else begin
          exp_v = 0; exp_i = NOP;
        end
      end

      if (hs_r) mem_busy = 0;
      if (arvalid && arready) begin
        mem_busy = 1; mem_addr = araddr; mem_delay = $urandom % 3;
      end else if (mem_busy && mem_delay > 0) begin
        mem_delay--;
      end
    end
    check_val("progress", (deliveries > 100) ? 32'd1 : 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
